hs_arbiter: RTL

Round-robin arbiter that shares one peripheral send/ack port between NUM_REQ CPU-side requesters, each using the same 4-phase send/ack handshake with a DATA_W-bit data word. It sits between the CPU FSMs and the peripheral FSM. It forwards exactly one transaction at a time, holds the data word stable for the full handshake, and synchronizes the peripheral's ack into the arbiter clock domain.

---
 rtl/hs_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/hs_arbiter.sv
// Round-robin arbiter sharing one 4-phase send/ack peripheral port between NUM_REQ requesters.
module hs_arbiter #(
  parameter  int NUM_REQ     = 4,
  parameter  int DATA_W      = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int GW          = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_send,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic                      per_send,
  output logic [DATA_W-1:0]         per_newData,
  input  logic                      per_ack,
  output logic [GW-1:0]             grant_id,
  output logic                      busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DROP = 2'd2,
    RELEASE   = 2'd3
  } state_t;

  localparam logic [GW-1:0] LAST_ID = GW'(NUM_REQ - 1);

  state_t              r_state;
  logic [GW-1:0]       r_ptr;
  logic                r_send;
  logic [DATA_W-1:0]   r_data;
  logic [GW-1:0]       r_gid;
  logic [NUM_REQ-1:0]  r_ack;
  logic                r_busy;

  state_t              w_state;
  logic [GW-1:0]       w_ptr;
  logic                w_send;
  logic [DATA_W-1:0]   w_data;
  logic [GW-1:0]       w_gid;
  logic [NUM_REQ-1:0]  w_ack;
  logic                w_busy;

  logic                w_ack_s;
  logic                w_found;
  logic [GW-1:0]       w_pick;
  logic [DATA_W-1:0]   w_words [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
    assign w_words[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  if (SYNC_STAGES == 0) begin : g_direct
    assign w_ack_s = per_ack;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_sync <= '0;
      end else begin
        r_sync[0] <= per_ack;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
          r_sync[i] <= r_sync[i-1];
        end
      end
    end

    assign w_ack_s = r_sync[SYNC_STAGES-1];
  end

  // First requester at or above ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [GW:0] sum;
    w_found = 1'b0;
    w_pick  = '0;
    sum     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, r_ptr} + (GW+1)'(k);
      if (sum >= (GW+1)'(NUM_REQ)) begin
        sum = sum - (GW+1)'(NUM_REQ);
      end
      if (!w_found && req_send[sum[GW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = sum[GW-1:0];
      end
    end
  end

  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_send  = r_send;
    w_data  = r_data;
    w_gid   = r_gid;
    w_ack   = r_ack;
    unique case (r_state)
      IDLE: begin
        if (w_found && !w_ack_s) begin
          w_gid   = w_pick;
          w_data  = w_words[w_pick];
          w_send  = 1'b1;
          w_state = SEND;
        end
      end
      SEND: begin
        if (w_ack_s) begin
          w_ack        = '0;
          w_ack[r_gid] = 1'b1;
          w_state      = WAIT_DROP;
        end
      end
      WAIT_DROP: begin
        if (!req_send[r_gid]) begin
          w_send  = 1'b0;
          w_state = RELEASE;
        end
      end
      RELEASE: begin
        if (!w_ack_s) begin
          w_ack   = '0;
          w_ptr   = (r_gid == LAST_ID) ? '0 : r_gid + 1'b1;
          w_state = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
    w_busy = (w_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_send  <= 1'b0;
      r_data  <= '0;
      r_gid   <= '0;
      r_ack   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_send  <= w_send;
      r_data  <= w_data;
      r_gid   <= w_gid;
      r_ack   <= w_ack;
      r_busy  <= w_busy;
    end
  end

  assign req_ack     = r_ack;
  assign per_send    = r_send;
  assign per_newData = r_data;
  assign grant_id    = r_gid;
  assign busy        = r_busy;

endmodule
